instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the processor's decode/execute datapath.
- Holds the fetch PC and loads startpc after reset.
- Issues word reads to instruction memory using a req/ack handshake, and buffers returned instructions in a small FIFO.
- Presents instructions with a valid/ready handshake, handles branch redirects with flush/squash, and stops fetching at finalpc.

Parameters:
- FIFO_DEPTH, 2, number of buffered instruction entries (power of 2, ≥2).
- PC_W, 64, PC width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- resetl  input  1  asynchronous active-low reset.
- startpc  input  PC_W  boot address; sampled in BOOT.
- finalpc  input  PC_W  fetch stops when fetch PC ≥ finalpc (unsigned).
- imem_req  output  1  instruction memory read request.
- imem_addr  output  PC_W  word address (bits[1:0]=0).
- imem_ack  input  1  read data valid, completes the request.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  branch/jump redirect.
- redirect_pc  input  PC_W  redirect target; bits[1:0] ignored, forced to 0.
- if_valid  output  1  head of FIFO valid.
- if_ready  input  1  consumer accepts.
- if_instr  output  32  head instruction.
- if_pc  output  PC_W  PC of head instruction.
- currentpc  output  PC_W  if_pc when if_valid, else fetch PC.
- halted  output  1  fetch stopped and FIFO empty.

Behaviour:
- Reset (resetl=0, asynchronous):
  - state=IDLE, fetch PC=0, FIFO empty, squash=0.
  - Outputs: imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, currentpc=0, halted=0.
- FSM states: IDLE, BOOT, FETCH, WAIT, HALT.
- IDLE: first posedge with resetl=1 → BOOT.
- BOOT: fetch PC <= {startpc[PC_W-1:2],2'b00}.
  - → HALT if that value ≥ finalpc, else → FETCH.
- FETCH:
  - Request condition: fetch PC < finalpc and FIFO free entries > 0.
  - When met: drive imem_req=1 and imem_addr=fetch PC in the same cycle (Moore-registered), → WAIT.
  - When fetch PC ≥ finalpc: → HALT.
- WAIT:
  - Hold imem_req=1 and imem_addr stable until imem_ack; no withdrawal.
  - On the ack cycle: if squash=0, push {imem_rdata, imem_addr} and set fetch PC <= fetch PC+4. If squash=1, drop the data and clear squash.
  - Then → FETCH; imem_req deasserts the cycle after ack.
  - Only one request is outstanding at a time.
- Ack latency: arbitrary, 1..N cycles. An ack while imem_req=0 is ignored.
- Output side:
  - if_valid = FIFO not empty.
  - Pop when if_valid && if_ready.
  - Push and pop in the same cycle are both honoured when the FIFO is full.
  - if_instr and if_pc are stable while if_valid && !if_ready.
- Redirect (any state except IDLE/BOOT):
  - Flush the FIFO; if_valid=0 on the next cycle.
  - Fetch PC <= aligned redirect_pc.
  - If in WAIT, set squash=1 and stay in WAIT until the ack arrives.
  - From HALT: → FETCH if target < finalpc, else stay in HALT.
  - Redirect beats a same-cycle ack (the ack is squashed) and a same-cycle pop (the pop is discarded).
- HALT:
  - imem_req=0.
  - halted=1 when the FIFO is empty; the FIFO continues to drain.
- PC wrap: fetch PC+4 wraps modulo 2^PC_W. A wrapped PC is below finalpc, so fetch continues.
- Reset mid-request: everything clears immediately. A late imem_ack after reset, while imem_req=0, is ignored.

Optional Feature:
- FETCH_PERF_EN
- Defined:
  - Adds output fetch_count [31:0], which counts pops (if_valid && if_ready), and output squash_count [15:0], which counts squashed acks plus flushed FIFO entries.
  - Both reset to 0 and saturate at all-ones.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Boot and basic fetch:
  - Stimulus: startpc=0x0, finalpc=0x14, 1-cycle ack, if_ready=1.
  - Required: if_pc sequence 0x0,0x4,0x8,0xC,0x10; imem_addr never shows 0x14; halted=1 after the last pop.
- Backpressure:
  - Stimulus: if_ready=0 for 10 cycles, FIFO_DEPTH=2.
  - Required: exactly 2 requests complete, then imem_req stays 0. if_pc holds 0x0. On release, instructions appear in order with no loss or duplication.
- Redirect during an outstanding request:
  - Stimulus: ack latency 3; redirect_valid with redirect_pc=0x43 on the 2nd WAIT cycle.
  - Required: the old data is dropped, the next imem_addr is 0x40, and the next if_pc is 0x40.
- Simultaneous redirect and ack:
  - Stimulus: redirect_pc=0x100 in the same cycle as the ack for 0x8.
  - Required: 0x8 is never presented, and the next request is 0x100.
- Async reset mid-WAIT:
  - Stimulus: drop resetl between clock edges, then send an ack afterwards.
  - Required: imem_req, if_valid and currentpc go to 0 immediately; the late ack is ignored; the reboot fetches from startpc.
- HALT resume:
  - Stimulus: halted with finalpc=0x14, then redirect_pc=0x4.
  - Required: fetch resumes at 0x4 and halts again after 0x10.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: boot PC load, single-outstanding imem req/ack, small FIFO, redirect flush/squash.
// Optional FETCH_PERF_EN adds fetch_count (pops) and squash_count (squashed acks + flushed entries).
module instr_fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int PC_W       = 64
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic [PC_W-1:0] startpc,
  input  logic [PC_W-1:0] finalpc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] currentpc,
  output logic            halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [15:0]     squash_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_W-1:0]  ALIGN_M = ~PC_W'(3);

  typedef enum logic [2:0] {IDLE, BOOT, FETCH, WAIT, HALT} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     fpc_q, fpc_d;
  logic [PC_W-1:0]     addr_q, addr_d;
  logic                squash_q, squash_d;
  logic                req_q;
  logic                push, pop, redir, sq_ack;
  logic [PC_W-1:0]     boot_pc, redir_pc;

  fetch_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0]    cnt_q;
  fetch_entry_t        head;

  assign boot_pc  = startpc & ALIGN_M;
  assign redir_pc = redirect_pc & ALIGN_M;

  // Next-state / fetch-PC logic. imem_ack is only meaningful in WAIT, where req is high.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    push     = 1'b0;
    redir    = 1'b0;
    sq_ack   = 1'b0;
    case (state_q)
      IDLE: state_d = BOOT;
      BOOT: begin
        fpc_d   = boot_pc;
        state_d = (boot_pc >= finalpc) ? HALT : FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          redir = 1'b1;
          fpc_d = redir_pc;
        end else if (fpc_q >= finalpc) begin
          state_d = HALT;
        end else if (cnt_q < DEPTH_C) begin
          state_d = WAIT;
          addr_d  = fpc_q;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          redir = 1'b1;
          fpc_d = redir_pc;
          // A same-cycle ack retires the request, so no squash is left pending.
          if (imem_ack) begin
            sq_ack   = 1'b1;
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_ack) begin
          state_d  = FETCH;
          squash_d = 1'b0;
          if (squash_q) begin
            sq_ack = 1'b1;
          end else begin
            push  = 1'b1;
            fpc_d = fpc_q + PC_W'(4);
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          redir = 1'b1;
          fpc_d = redir_pc;
          if (redir_pc < finalpc) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q  <= IDLE;
      fpc_q    <= '0;
      addr_q   <= '0;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      req_q    <= (state_d == WAIT);
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  // Instruction FIFO; redirect flushes and swallows any same-cycle pop.
  assign if_valid = (cnt_q != '0);
  assign pop      = if_valid && if_ready && !redir;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (redir) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !redir) mem[wr_q] <= {imem_rdata, addr_q};
  end

  assign head      = mem[rd_q];
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc    : '0;
  assign currentpc = if_valid ? head.pc    : fpc_q;
  assign halted    = (state_q == HALT) && !if_valid;

`ifdef FETCH_PERF_EN
  logic [16:0] sq_sum;

  always_comb begin
    sq_sum = {1'b0, squash_count} + (redir ? 17'(cnt_q) : 17'd0) + 17'(sq_ack);
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (pop && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      squash_count <= sq_sum[16] ? '1 : sq_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios, imem responder, pop monitor.
module tb_instr_fetch_unit;
  localparam int PC_W = 64;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic            CLK = 1'b0;
  logic            resetl = 1'b0;
  logic [PC_W-1:0] startpc = '0;
  logic [PC_W-1:0] finalpc = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic [PC_W-1:0] currentpc;
  logic            halted;
`ifdef FETCH_PERF_EN
  logic [31:0]     fetch_count;
  logic [15:0]     squash_count;
`endif

  int   n_chk = 0, n_pass = 0, n_acks = 0, n_viol = 0;
  int   lat = 1;
  bit   resp_en = 1'b1, force_ack = 1'b0;
  exp_t sb[$];

  instr_fetch_unit #(.FIFO_DEPTH(2), .PC_W(PC_W)) dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc), .finalpc(finalpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .currentpc(currentpc), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [63:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout, want event within budget", nm);
  endtask

  task automatic expect_seq(input logic [63:0] first, input logic [63:0] last);
    for (logic [63:0] pc = first; pc <= last; pc += 64'd4) sb.push_back('{pc, memf(pc)});
  endtask

  task automatic responder();
    int wcnt = 0;
    forever begin
      @(negedge CLK);
      if (imem_ack) imem_ack = 1'b0;
      else if (force_ack) begin
        imem_ack = 1'b1; imem_rdata = memf(imem_addr);
      end else if (resp_en && imem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          imem_ack = 1'b1; imem_rdata = memf(imem_addr); wcnt = 0; n_acks++;
        end
      end else wcnt = 0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK); #2;
      if (resetl && imem_req && ((imem_addr >= finalpc) || (imem_addr[1:0] != 2'b00))) n_viol++;
      if (resetl && if_valid && if_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pop: got pc %h, want no output", if_pc);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", if_pc, e.pc);
          chk("pop_instr", 64'(if_instr), 64'(e.instr));
        end
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] sp, input logic [63:0] fp, input int l, input logic rdy);
    @(posedge CLK); #1;
    lat = l; resp_en = 1'b1;
    @(negedge CLK);
    resetl = 1'b0; redirect_valid = 1'b0; startpc = sp; finalpc = fp; if_ready = rdy;
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
  endtask

  task automatic wait_req(input logic want, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (imem_req === want) done = 1'b1;
    end
    if (!done) timeout_fail(nm);
  endtask

  task automatic wait_drain_halt(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK); #3;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      timeout_fail(nm);
      sb.delete();
    end
    @(negedge CLK); #3;
    chk(nm, halted, 1'b1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 64'h0);
    chk({tag, "_valid"}, if_valid, 1'b0);
    chk({tag, "_instr"}, 64'(if_instr), 64'h0);
    chk({tag, "_ifpc"}, if_pc, 64'h0);
    chk({tag, "_curpc"}, currentpc, 64'h0);
    chk({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    int a0;
    bit done;
    fork
      responder();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge CLK);
    reset_outputs("rst");

    // Boot and basic fetch
    expect_seq(64'h0, 64'h10);
    do_reset(64'h0, 64'h14, 1, 1'b1);
    wait_drain_halt("basic_halted");

    // Backpressure: two fills then idle
    a0 = n_acks;
    do_reset(64'h0, 64'h14, 1, 1'b0);
    repeat (12) @(negedge CLK);
    chk("bp_acks", 64'(n_acks - a0), 64'd2);
    chk("bp_req_idle", imem_req, 1'b0);
    chk("bp_valid", if_valid, 1'b1);
    chk("bp_ifpc", if_pc, 64'h0);
    chk("bp_instr", 64'(if_instr), 64'(memf(64'h0)));
    expect_seq(64'h0, 64'h10);
    if_ready = 1'b1;
    wait_drain_halt("bp_halted");

    // Redirect on the 2nd WAIT cycle of an outstanding request
    do_reset(64'h0, 64'h48, 3, 1'b0);
    wait_req(1'b1, "rw_first_req");
    @(negedge CLK);
    redirect_valid = 1'b1; redirect_pc = 64'h43;
    @(negedge CLK);
    redirect_valid = 1'b0;
    wait_req(1'b0, "rw_req_drop");
    chk("rw_no_stale", if_valid, 1'b0);
    wait_req(1'b1, "rw_next_req");
    chk("rw_next_addr", imem_addr, 64'h40);
    expect_seq(64'h40, 64'h44);
    if_ready = 1'b1;
    wait_drain_halt("rw_halted");

    // Redirect in the same cycle as the ack for 0x8
    sb.push_back('{64'h0, memf(64'h0)});
    sb.push_back('{64'h4, memf(64'h4)});
    do_reset(64'h0, 64'h108, 1, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (imem_req && imem_addr == 64'h8) done = 1'b1;
    end
    if (!done) timeout_fail("ra_find_8");
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    @(negedge CLK);
    redirect_valid = 1'b0;
    chk("ra_req_drop", imem_req, 1'b0);
    chk("ra_no_8", if_valid, 1'b0);
    wait_req(1'b1, "ra_next_req");
    chk("ra_next_addr", imem_addr, 64'h100);
    expect_seq(64'h100, 64'h104);
    wait_drain_halt("ra_halted");

    // Async reset mid-WAIT, then a late ack
    do_reset(64'h20, 64'h40, 1, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (if_valid) done = 1'b1;
    end
    if (!done) timeout_fail("ar_first_fill");
    @(posedge CLK); #1;
    resp_en = 1'b0;
    @(negedge CLK);
    chk("ar_in_wait", imem_req, 1'b1);
    #3;
    resetl = 1'b0;
    #1;
    reset_outputs("ar");
    @(posedge CLK); #1;
    force_ack = 1'b1; resetl = 1'b1;
    @(negedge CLK); #1;
    force_ack = 1'b0;
    @(posedge CLK); #1;
    resp_en = 1'b1;
    expect_seq(64'h20, 64'h3C);
    @(negedge CLK);
    if_ready = 1'b1;
    wait_drain_halt("ar_halted");

    // HALT resume, then redirect beyond finalpc
    expect_seq(64'h0, 64'h10);
    do_reset(64'h1, 64'h14, 2, 1'b1);
    wait_drain_halt("hr_halted1");
    chk("hr_curpc_final", currentpc, 64'h14);
    @(negedge CLK);
    redirect_valid = 1'b1; redirect_pc = 64'h4;
    expect_seq(64'h4, 64'h10);
    @(negedge CLK);
    redirect_valid = 1'b0;
    chk("hr_resumed", halted, 1'b0);
    wait_drain_halt("hr_halted2");
    @(negedge CLK);
    redirect_valid = 1'b1; redirect_pc = 64'h20;
    @(negedge CLK);
    redirect_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("hr_stay_halt", halted, 1'b1);
    chk("hr_no_req", imem_req, 1'b0);
    chk("hr_curpc", currentpc, 64'h20);

    // Boot address already at finalpc
    a0 = n_acks;
    do_reset(64'h14, 64'h14, 1, 1'b1);
    repeat (6) @(negedge CLK);
    chk("bh_halted", halted, 1'b1);
    chk("bh_acks", 64'(n_acks - a0), 64'd0);
    chk("bh_curpc", currentpc, 64'h14);

    chk("addr_violations", 64'(n_viol), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
